// File: rtl/line_follow_pkg.sv
// rtl/line_follow_pkg.sv - shared state type, default constants and saturation helpers for line_follow_pid
package line_follow_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    STOP  = 2'd2
  } lf_state_e;

  localparam int DEF_THR      = 350;
  localparam int DEF_ERR_STEP = 3;
  localparam int DEF_KP       = 4;
  localparam int DEF_KI       = 0;
  localparam int DEF_KD       = 3;
  localparam int DEF_I_LIM    = 30;
  localparam int DEF_BASE_PWM = 22;
  localparam int DEF_DUTY_MAX = 255;
  localparam int DEF_LOST_LIM = 200;

  // Largest positive value of a signed word of width w.
  function automatic int smax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int clamp(input int x, input int lo, input int hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic int sat_sym(input int x, input int lim);
    return clamp(x, -lim, lim);
  endfunction

endpackage

// File: rtl/line_follow_pid_if.sv
// rtl/line_follow_pid_if.sv - sensor sample in / motor command out bundle for line_follow_pid
interface line_follow_pid_if #(
  parameter int N_SENS = 3,
  parameter int ADC_W  = 12,
  parameter int OUT_W  = 9
);
  logic                      en;
  logic                      sample_valid;
  logic [N_SENS*ADC_W-1:0]   sens;
  logic signed [OUT_W-1:0]   duty_l;
  logic signed [OUT_W-1:0]   duty_r;
  logic signed [OUT_W-1:0]   delta;
  logic                      out_valid;
  logic                      lost;
  logic                      stopped;
  logic [7:0]                node_cnt;

  modport master (
    output en, sample_valid, sens,
    input  duty_l, duty_r, delta, out_valid, lost, stopped, node_cnt
  );

  modport slave (
    input  en, sample_valid, sens,
    output duty_l, duty_r, delta, out_valid, lost, stopped, node_cnt
  );
endinterface

// File: rtl/line_pos_enc.sv
// rtl/line_pos_enc.sv - thresholds the sensor words and turns the leftmost/rightmost active channels into a signed error
module line_pos_enc #(
  parameter int N_SENS   = 3,
  parameter int ADC_W    = 12,
  parameter int THR      = 350,
  parameter int ERR_STEP = 3,
  parameter int OUT_W    = 9
) (
  input  logic [N_SENS*ADC_W-1:0] sens_i,
  output logic                    any_o,
  output logic                    all_o,
  output logic signed [OUT_W-1:0] err_o
);
  logic [N_SENS-1:0] act;

  always_comb begin
    int l;
    int r;
    act = '0;
    l   = 0;
    r   = 0;
    for (int i = 0; i < N_SENS; i++) begin
      act[i] = sens_i[i*ADC_W +: ADC_W] > ADC_W'(THR);
    end
    for (int i = N_SENS - 1; i >= 0; i--) begin
      if (act[i]) l = i;
    end
    for (int i = 0; i < N_SENS; i++) begin
      if (act[i]) r = i;
    end
    any_o = |act;
    all_o = &act;
    // A junction reads as centred; a dark sample's error is replaced downstream.
    err_o = '0;
    if (any_o && !all_o) begin
      err_o = OUT_W'((l + r - (N_SENS - 1)) * ERR_STEP);
    end
  end
endmodule

// File: rtl/line_follow_pid.sv
// rtl/line_follow_pid.sv - 3-stage line-follower PID: encode, error/integral update, delta and duty saturation
module line_follow_pid
  import line_follow_pkg::*;
#(
  parameter int N_SENS   = 3,
  parameter int ADC_W    = 12,
  parameter int THR      = DEF_THR,
  parameter int ERR_STEP = DEF_ERR_STEP,
  parameter int KP       = DEF_KP,
  parameter int KI       = DEF_KI,
  parameter int KD       = DEF_KD,
  parameter int I_LIM    = DEF_I_LIM,
  parameter int BASE_PWM = DEF_BASE_PWM,
  parameter int DUTY_MAX = DEF_DUTY_MAX,
  parameter int OUT_W    = 9,
  parameter int LOST_LIM = DEF_LOST_LIM
) (
  input logic              clk_50,
  input logic              rst_n,
  line_follow_pid_if.slave bus
);
  localparam int CALC_W = OUT_W + 10;
  localparam int CNT_W  = $clog2(LOST_LIM + 1);

  logic                    enc_any, enc_all;
  logic signed [OUT_W-1:0] enc_err;
  logic                    v1_q, any1_q, all1_q;
  logic signed [OUT_W-1:0] err1_q;

  line_pos_enc #(
    .N_SENS(N_SENS), .ADC_W(ADC_W), .THR(THR), .ERR_STEP(ERR_STEP), .OUT_W(OUT_W)
  ) u_enc (
    .sens_i(bus.sens),
    .any_o (enc_any),
    .all_o (enc_all),
    .err_o (enc_err)
  );

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      any1_q <= 1'b0;
      all1_q <= 1'b0;
      err1_q <= '0;
    end else begin
      v1_q <= bus.sample_valid && bus.en;
      if (bus.sample_valid) begin
        any1_q <= enc_any;
        all1_q <= enc_all;
        err1_q <= enc_err;
      end
    end
  end

  lf_state_e                state_q, state_d;
  logic                     v2_q, lost2_q, prev_all_q;
  logic signed [OUT_W-1:0]  err_q, err_d, integ_q, integ_d;
  logic signed [CALC_W-1:0] diff_q, diff_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [7:0]               node_q, node_d;

  always_comb begin
    err_d   = any1_q ? err1_q : err_q;
    diff_d  = CALC_W'(err_d) - CALC_W'(err_q);
    integ_d = OUT_W'(clamp(int'(integ_q) + int'(err_d), -I_LIM, I_LIM));
    node_d  = (all1_q && !prev_all_q) ? node_q + 8'd1 : node_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (any1_q) begin
      cnt_d   = '0;
      state_d = TRACK;
      if (state_q == STOP) integ_d = '0;
    end else begin
      if (cnt_q != CNT_W'(LOST_LIM)) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(LOST_LIM)) state_d = STOP;
      else if (state_q == IDLE)      state_d = TRACK;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      v2_q       <= 1'b0;
      lost2_q    <= 1'b0;
      prev_all_q <= 1'b0;
      err_q      <= '0;
      integ_q    <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      node_q     <= '0;
    end else if (!bus.en) begin
      // Dropping enable discards the in-flight sample instead of committing it.
      state_q <= IDLE;
      integ_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        state_q    <= state_d;
        err_q      <= err_d;
        diff_q     <= diff_d;
        integ_q    <= integ_d;
        cnt_q      <= cnt_d;
        node_q     <= node_d;
        prev_all_q <= all1_q;
        lost2_q    <= !any1_q;
      end
    end
  end

  logic signed [CALC_W-1:0] pid_sum;
  logic signed [OUT_W-1:0]  delta_d, duty_l_d, duty_r_d;
  logic signed [OUT_W-1:0]  delta_q, duty_l_q, duty_r_q;
  logic                     out_valid_q, lost_q, stopped_q;
  logic [7:0]               node_cnt_q;

  always_comb begin
    pid_sum = CALC_W'(KP) * CALC_W'(err_q) + CALC_W'(KI) * CALC_W'(integ_q) + CALC_W'(KD) * diff_q;
    delta_d  = OUT_W'(sat_sym(int'(pid_sum), smax(OUT_W)));
    duty_l_d = '0;
    duty_r_d = '0;
    if (state_q == TRACK) begin
      duty_l_d = OUT_W'(sat_sym(BASE_PWM - int'(delta_d), DUTY_MAX));
      duty_r_d = OUT_W'(sat_sym(BASE_PWM + int'(delta_d), DUTY_MAX));
    end
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      delta_q     <= '0;
      duty_l_q    <= '0;
      duty_r_q    <= '0;
      lost_q      <= 1'b0;
      stopped_q   <= 1'b0;
      node_cnt_q  <= '0;
    end else begin
      out_valid_q <= v2_q && bus.en;
      if (v2_q && bus.en) begin
        delta_q    <= delta_d;
        duty_l_q   <= duty_l_d;
        duty_r_q   <= duty_r_d;
        lost_q     <= lost2_q;
        stopped_q  <= (state_q == STOP);
        node_cnt_q <= node_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.delta     = delta_q;
  assign bus.duty_l    = duty_l_q;
  assign bus.duty_r    = duty_r_q;
  assign bus.lost      = lost_q;
  assign bus.stopped   = stopped_q;
  assign bus.node_cnt  = node_cnt_q;
endmodule

// File: tb/tb_line_follow_pid.sv
// tb/tb_line_follow_pid.sv - directed bench for line_follow_pid with a per-sample reference model (KI=0 and KI=1 instances)
module tb_line_follow_pid;
  logic        clk_50 = 1'b0;
  logic        rst_n, en, sv;
  logic [35:0] sens;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  line_follow_pid_if #(.N_SENS(3), .ADC_W(12), .OUT_W(9)) b0 ();
  line_follow_pid_if #(.N_SENS(3), .ADC_W(12), .OUT_W(9)) b1 ();

  assign b0.en = en;
  assign b0.sample_valid = sv;
  assign b0.sens = sens;
  assign b1.en = en;
  assign b1.sample_valid = sv;
  assign b1.sens = sens;

  line_follow_pid dut0 (.clk_50(clk_50), .rst_n(rst_n), .bus(b0));
  line_follow_pid #(.KI(1)) dut1 (.clk_50(clk_50), .rst_n(rst_n), .bus(b1));

  typedef struct {
    int cyc;
    int dlt0, dl0, dr0;
    int dlt1, dl1, dr1;
    int lost, stp, node;
  } exp_t;

  exp_t q[$];
  int   m_prev, m_cnt, m_st, m_node;
  bit   m_prev_all;
  int   m_integ[2];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampi(input int x, input int lo, input int hi);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic logic [35:0] mk(input int c0, input int c1, input int c2);
    return {12'(c2), 12'(c1), 12'(c0)};
  endfunction

  task automatic model_reset();
    m_prev = 0; m_cnt = 0; m_st = 0; m_node = 0; m_prev_all = 0;
    m_integ[0] = 0; m_integ[1] = 0;
    q.delete();
  endtask

  // m_st: 0 idle, 1 tracking, 2 stopped
  task automatic model_push(input logic [35:0] s);
    exp_t e;
    int   l, r, n, err, diff, p;
    int   dlt[2], dl[2], dr[2];
    bit   all_a, recover;
    l = -1; r = -1; n = 0; recover = 0;
    for (int i = 0; i < 3; i++) begin
      if (s[i*12 +: 12] > 12'd350) begin
        if (l < 0) l = i;
        r = i;
        n++;
      end
    end
    all_a = (n == 3);
    if (n == 0) begin
      err = m_prev;
      e.lost = 1;
      if (m_cnt < 200) m_cnt++;
      if (m_cnt >= 200) m_st = 2;
      else m_st = 1;
    end else begin
      err = all_a ? 0 : (l + r - 2) * 3;
      e.lost = 0;
      m_cnt = 0;
      recover = (m_st == 2);
      m_st = 1;
    end
    if (all_a && !m_prev_all) m_node = (m_node + 1) % 256;
    m_prev_all = all_a;
    diff = err - m_prev;
    m_prev = err;
    for (int k = 0; k < 2; k++) begin
      m_integ[k] = recover ? 0 : clampi(m_integ[k] + err, -30, 30);
      p = 4 * err + k * m_integ[k] + 3 * diff;
      dlt[k] = clampi(p, -255, 255);
      dl[k] = (m_st == 1) ? clampi(22 - dlt[k], -255, 255) : 0;
      dr[k] = (m_st == 1) ? clampi(22 + dlt[k], -255, 255) : 0;
    end
    e.dlt0 = dlt[0]; e.dl0 = dl[0]; e.dr0 = dr[0];
    e.dlt1 = dlt[1]; e.dl1 = dl[1]; e.dr1 = dr[1];
    e.stp  = (m_st == 2);
    e.node = m_node;
    e.cyc  = cyc + 3;
    q.push_back(e);
  endtask

  task automatic send(input logic [35:0] s);
    sv = 1'b1;
    sens = s;
    model_push(s);
    @(posedge clk_50); #1;
    sv = 1'b0;
    sens = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_50); #1;
    end
  endtask

  exp_t ce;
  always @(negedge clk_50) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      ce = q.pop_front();
      chk("ov0", int'(b0.out_valid), 1);
      chk("ov1", int'(b1.out_valid), 1);
      chk("delta0", int'(b0.delta), ce.dlt0);
      chk("duty_l0", int'(b0.duty_l), ce.dl0);
      chk("duty_r0", int'(b0.duty_r), ce.dr0);
      chk("delta1", int'(b1.delta), ce.dlt1);
      chk("duty_l1", int'(b1.duty_l), ce.dl1);
      chk("duty_r1", int'(b1.duty_r), ce.dr1);
      chk("lost", int'(b0.lost), ce.lost);
      chk("stopped", int'(b0.stopped), ce.stp);
      chk("node_cnt", int'(b0.node_cnt), ce.node);
    end else begin
      chk("ov0_quiet", int'(b0.out_valid), 0);
      chk("ov1_quiet", int'(b1.out_valid), 0);
    end
  end

  localparam logic [35:0] DARK = 36'h0;

  initial begin
    rst_n = 1'b0; en = 1'b0; sv = 1'b0; sens = '0;
    model_reset();
    idle(2);
    chk("rst_ov", int'(b0.out_valid), 0);
    chk("rst_duty_l", int'(b0.duty_l), 0);
    chk("rst_duty_r", int'(b0.duty_r), 0);
    chk("rst_delta", int'(b0.delta), 0);
    chk("rst_flags", int'({b0.lost, b0.stopped}), 0);
    chk("rst_node", int'(b0.node_cnt), 0);
    rst_n = 1'b1; en = 1'b1;
    idle(1);

    send(mk(0, 900, 0));
    idle(4);
    chk("centre_delta", int'(b0.delta), 0);
    chk("centre_duty_l", int'(b0.duty_l), 22);
    chk("centre_duty_r", int'(b0.duty_r), 22);

    send(mk(0, 0, 900));
    idle(4);
    chk("right1_delta", int'(b0.delta), 42);
    chk("right1_duty_l", int'(b0.duty_l), -20);
    chk("right1_duty_r", int'(b0.duty_r), 64);
    send(mk(0, 0, 900));
    idle(4);
    chk("right2_delta", int'(b0.delta), 24);
    chk("right2_duty_l", int'(b0.duty_l), -2);
    chk("right2_duty_r", int'(b0.duty_r), 46);

    send(mk(0, 0, 900));
    repeat (199) send(DARK);
    idle(4);
    chk("dark199_stopped", int'(b0.stopped), 0);
    chk("dark199_lost", int'(b0.lost), 1);
    chk("dark199_duty_l", int'(b0.duty_l), -2);
    send(DARK);
    idle(4);
    chk("dark200_stopped", int'(b0.stopped), 1);
    chk("dark200_duty_l", int'(b0.duty_l), 0);
    chk("dark200_duty_r", int'(b0.duty_r), 0);
    send(mk(0, 900, 0));
    idle(4);
    chk("resume_stopped", int'(b0.stopped), 0);
    chk("resume_delta", int'(b0.delta), -18);
    chk("resume_duty_l", int'(b0.duty_l), 40);
    chk("resume_delta_ki", int'(b1.delta), -18);

    send(mk(900, 900, 900));
    send(mk(900, 900, 900));
    idle(4);
    chk("node_b2b", int'(b0.node_cnt), 1);
    send(mk(0, 900, 0));
    send(mk(900, 900, 900));
    idle(4);
    chk("node_second", int'(b0.node_cnt), 2);

    repeat (10) send(mk(0, 0, 900));
    idle(4);
    chk("ki_pos_delta", int'(b1.delta), 54);
    chk("ki_pos_duty_l", int'(b1.duty_l), -32);
    chk("ki_pos_duty_r", int'(b1.duty_r), 76);
    repeat (10) send(mk(900, 0, 0));
    idle(4);
    chk("ki_neg_delta", int'(b1.delta), -54);
    chk("ki_neg_duty_l", int'(b1.duty_l), 76);
    chk("ki_neg_duty_r", int'(b1.duty_r), -32);

    send(mk(0, 0, 900));
    send(mk(0, 0, 900));
    rst_n = 1'b0;
    model_reset();
    idle(1);
    rst_n = 1'b1;
    idle(3);
    chk("flush_delta", int'(b0.delta), 0);
    chk("flush_duty_l", int'(b0.duty_l), 0);
    chk("flush_node", int'(b0.node_cnt), 0);
    send(mk(0, 900, 0));
    idle(4);
    chk("post_rst_duty_l", int'(b0.duty_l), 22);
    chk("post_rst_duty_r", int'(b0.duty_r), 22);

    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/line_follow_pid.md
# line_follow_pid

Parametrised line-follower controller. It thresholds N_SENS ADC channel words, derives a signed line-position error, runs a sample-gated PID loop with a clamped integral, and produces signed left/right motor duty commands for the motor PWM block. It also adds lost-line timeout, stop handling and junction counting. It sits between adc_control (sensor words plus a sample strobe) and the motor driver.

## Interface
- N_SENS, 3: sensor channel count (≥2)
- ADC_W, 12: ADC word width
- THR, 350: active threshold; a channel is active when its word is strictly greater than THR (unsigned)
- ERR_STEP, 3: error units per half sensor pitch
- KP, 4 / KI, 0 / KD, 3: unsigned gains, 8 bits each
- I_LIM, 30: integral clamp magnitude
- BASE_PWM, 22: nominal duty
- DUTY_MAX, 255: duty saturation magnitude
- OUT_W, 9: signed width of error, delta and duty
- LOST_LIM, 200: consecutive all-dark samples before STOP
- clk_50  in  1  system clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  run enable
- sample_valid  in  1  one-cycle strobe; sens is valid in that cycle
- sens  in  N_SENS*ADC_W  channel words; channel i occupies bits [i*ADC_W +: ADC_W]; channel 0 is leftmost
- duty_l, duty_r  out  OUT_W signed  motor commands
- delta  out  OUT_W signed  PID correction
- out_valid  out  1  one-cycle strobe when the outputs update
- lost  out  1  current sample is all-dark
- stopped  out  1  state is STOP
- node_cnt  out  8  junction count

## Operation
- Reset: every output is 0; state IDLE; error, prev_error, integral and lost counter are 0.
- States:
  - IDLE: duties are 0. Go to TRACK on the first sample_valid with en=1.
  - TRACK: normal PID operation.
  - STOP: duties are 0 and stopped=1. Return to TRACK on a sample with at least one active bit; the integral is cleared on that transition.
  - en=0 from any state forces IDLE on the next clock and clears the integral.
- Per sample, let act[i] be the threshold result for channel i.
- Error:
  - If any bit is active: l = lowest active index, r = highest active index, error = (l + r − (N_SENS−1)) × ERR_STEP.
  - All dark: error = prev_error, lost=1, lost counter increments. When the counter reaches LOST_LIM, go to STOP. Any active sample clears the counter.
  - All active (junction): error = 0. node_cnt increments only on a not-all-active to all-active transition between consecutive samples, and wraps at 255.
- PID:
  - diff = error − prev_error
  - integral = clamp(integral + error, −I_LIM, +I_LIM), using signed compare
  - delta = sat(KP·error + KI·integral + KD·diff) to ±(2^(OUT_W−1)−1)
  - Intermediate products are computed at OUT_W+10 bits with no overflow.
- Outputs: duty_l = sat(BASE_PWM − delta, ±DUTY_MAX); duty_r = sat(BASE_PWM + delta, ±DUTY_MAX).
- State is not advanced in cycles without sample_valid; all outputs hold their values.

## Timing
- 3-stage pipeline:
  - S1: threshold and encode
  - S2: error, diff and integral update
  - S3: delta and duty saturation
- out_valid is asserted 3 cycles after sample_valid. Throughput is one sample per cycle.
- lost, stopped and node_cnt update in the same cycle as out_valid.
- A sample_valid arriving while earlier samples are in flight is pipelined normally; samples are never dropped.
- rst_n low or en low mid-pipeline flushes in-flight samples: no out_valid is produced for them. rst_n takes priority over en.
- If a LOST_LIM-th dark sample and en=0 occur in the same cycle, the result is IDLE.

## Structure
- Package line_follow_pkg holds:
  - the state enum (IDLE, TRACK, STOP)
  - the sat/clamp width helpers
  - default gain and threshold constants
- Sub-module line_pos_enc: combinational threshold plus leftmost/rightmost encoding. It is parametrised by N_SENS, ADC_W and THR, and produces any, all and error.

## Test plan
- Defaults, centre line only (sens = {0, 900, 0}, channel 1 active) → error 0, delta 0, duty_l = duty_r = 22, out_valid 3 cycles after sample_valid.
- Only channel 2 active, repeated → error 6. First sample: delta = 4·6 + 3·6 = 42, duty_l = −20, duty_r = 64. Second sample: delta 24, duty_l = −2, duty_r = 46.
- Single active sample followed by LOST_LIM all-dark samples → error holds at 6 and lost=1 throughout. stopped=1 and duties 0 after the 200th dark sample. An active sample then returns to TRACK with the integral at 0.
- All-active sample, then centre, then all-active again → node_cnt counts 1 then 2. Back-to-back all-active samples keep node_cnt at 1.
- KI=1, I_LIM=30, error 6 held for 10 samples → integral saturates at 30, never exceeding it. The mirror case (error −6) saturates at −30.
- rst_n low for one cycle while 2 samples are in flight → no out_valid, all outputs 0, state IDLE. A new sample resumes with out_valid after 3 cycles.
